// File: rtl/mem_access_unit.sv
// mem_access_unit: splits byte-addressed B/H/W/D loads/stores into aligned 64-bit bus beats
package ControllerPack;
  typedef enum logic [2:0] {MEM_NO, MEM_B, MEM_H, MEM_W, MEM_D, MEM_UB, MEM_UH, MEM_UW} mem_op_enum;
endpackage

module mem_access_unit
  import ControllerPack::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_re,
  input  mem_op_enum        req_mem_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state, nxt;
  mem_op_enum st_op;
  logic st_we, split, nop, accept, ack0, ack1, split_n;
  logic [2:0] off;
  logic [3:0] sz;
  logic [127:0] w_sh;
  logic [15:0] m_sh;
  logic [63:0] wd_hi, lo, lo_v, hi_v, r, ext;
  logic [7:0] mk_hi;
  always_comb begin
    sz = (req_mem_op == MEM_B || req_mem_op == MEM_UB) ? 4'd1 :
         (req_mem_op == MEM_H || req_mem_op == MEM_UH) ? 4'd2 :
         (req_mem_op == MEM_W || req_mem_op == MEM_UW) ? 4'd4 :
         (req_mem_op == MEM_D) ? 4'd8 : 4'd0;
    nop = sz == 4'd0 || !(req_we || req_re);
    accept = state == IDLE && req_valid;
    split_n = {1'b0, req_addr[2:0]} + sz > 4'd8;
    w_sh = {64'd0, req_wdata} << {req_addr[2:0], 3'b000};
    m_sh = ((16'd1 << sz) - 16'd1) << req_addr[2:0];
    ack0 = state == BEAT0 && mem_ack;
    ack1 = state == BEAT1 && mem_ack;
    lo_v = ack0 ? mem_rdata : lo;
    hi_v = ack1 ? mem_rdata : 64'd0;
    r = 64'({hi_v, lo_v} >> {off, 3'b000});
    ext = st_op == MEM_B  ? {{56{r[7]}}, r[7:0]} :
          st_op == MEM_H  ? {{48{r[15]}}, r[15:0]} :
          st_op == MEM_W  ? {{32{r[31]}}, r[31:0]} :
          st_op == MEM_UB ? {56'd0, r[7:0]} :
          st_op == MEM_UH ? {48'd0, r[15:0]} :
          st_op == MEM_UW ? {32'd0, r[31:0]} : r;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? (nop ? RESP : BEAT0) : IDLE;
      BEAT0:   nxt = mem_ack ? (split ? BEAT1 : RESP) : BEAT0;
      BEAT1:   nxt = mem_ack ? RESP : BEAT1;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= nxt;
  end
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  // bus outputs are registered so mem_ack never reaches an output combinationally
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_we <= 1'b0;
      st_op <= MEM_NO;
      off <= '0;
      split <= 1'b0;
      wd_hi <= '0;
      mk_hi <= '0;
      lo <= '0;
      resp_rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (accept) begin
      st_we <= req_we;
      st_op <= req_mem_op;
      off <= req_addr[2:0];
      split <= split_n;
      wd_hi <= req_we ? w_sh[127:64] : '0;
      mk_hi <= req_we ? m_sh[15:8] : '0;
      resp_rdata <= '0;
      mem_req <= !nop;
      mem_we <= !nop && req_we;
      mem_addr <= nop ? '0 : {req_addr[ADDR_W-1:3], 3'b000};
      mem_wdata <= !nop && req_we ? w_sh[63:0] : '0;
      mem_wmask <= !nop && req_we ? m_sh[7:0] : '0;
    end else if (ack0 && split) begin
      lo <= mem_rdata;
      mem_addr <= mem_addr + ADDR_W'(8);
      mem_wdata <= wd_hi;
      mem_wmask <= mk_hi;
    end else if (ack0 || ack1) begin
      resp_rdata <= st_we ? '0 : ext;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end
  end
endmodule
